overlay_mac_job_sequencer: RTL and testbench
============================================

Name: overlay_mac_job_sequencer

Overview:
- Sequences dot-product / accumulate jobs onto one Overlay C2x2 F1 16x16 MAC instance.
- Per job, accepts a config: SIMD mode, operand signs, beat count and 32-bit bias.
- Streams operand pairs into the MAC's a/b ports and steers the MAC accumulator input (result_2) between the bias and the fed-back S_reg.
- Drains the MAC pipeline and returns the final accumulated word and SIMD carries through a valid/ready result port.

Parameters:
- MULT_LAT, 2, register stages inside the MAC multiplier, counted from the a/b ports to the result_0/result_1 outputs.
- LEN_W, 16, width of the job beat count.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- job_valid  in  1  job config valid
- job_ready  out  1  sequencer accepts a job
- job_mode  in  2  SIMD mode, passed through to the MAC
- job_a_sign  in  1  signedness of a
- job_b_sign  in  1  signedness of b
- job_len  in  LEN_W  number of operand beats
- job_bias  in  32  accumulator initial value
- op_valid  in  1  operand pair valid
- op_ready  out  1  operand pair accepted
- op_a  in  32  operand a
- op_b  in  32  operand b
- mac_mode  out  2  to MAC mode
- mac_a  out  32  to MAC a
- mac_b  out  32  to MAC b
- mac_a_sign  out  1  to MAC a_sign
- mac_b_sign  out  1  to MAC b_sign
- mac_result_2  out  32  to MAC result_2 (accumulator input)
- mac_cin  out  1  to MAC CIN, constant 0
- mac_s  in  32  from MAC S_reg
- mac_carry  in  4  from MAC result_SIMD_carry_out_reg
- res_valid  out  1  result valid
- res_ready  in  1  result consumed
- res_data  out  32  final accumulator value
- res_carry  out  4  final SIMD carry-out

Behaviour:
- Reset state:
  - State is IDLE.
  - All registered outputs are 0: mac_mode, mac_a, mac_b, mac_a_sign, mac_b_sign, res_valid, res_data, res_carry.
  - First-beat delay line and beat counter are cleared.
  - job_ready is 1 the cycle after reset deasserts. op_ready is 0.
- Reset asserted mid-job discards all in-flight beats and any pending result; no res_valid is produced for that job.
- State machine:
  - IDLE:
    - job_ready=1.
    - On a job_valid&job_ready handshake, register mode, signs and bias into the mac_* and bias registers, and load the counter with job_len.
    - Go to RUN; if job_len==0, go to DONE instead.
  - RUN:
    - op_ready=1.
    - On each op handshake, register op_a/op_b into mac_a/mac_b and decrement the counter.
    - A cycle with no handshake drives mac_a=mac_b=0 (a zero-product bubble).
    - After the handshake that brings the counter to 0, go to DRAIN. op_ready deasserts from the next cycle.
  - DRAIN:
    - Wait MULT_LAT+2 cycles, then capture mac_s into res_data and mac_carry into res_carry, and set res_valid.
    - Go to DONE.
  - DONE:
    - res_valid=1.
    - res_data and res_carry hold stable until res_ready; job_ready=0.
    - On res_ready, clear res_valid and go to IDLE.
- Zero-length job: res_data=bias and res_carry=0. res_valid rises the cycle after the job handshake.
- Timing, with handshake at cycle t:
  - mac_a/mac_b carry the beat at t+1.
  - The product reaches the ALU stage at t+MULT_LAT+2.
  - S_reg for the beat is valid at t+MULT_LAT+3.
- mac_result_2 (combinational mux):
  - Equals bias when the first-beat flag, delayed MULT_LAT+2 cycles from the first op handshake of the job, is set.
  - Otherwise equals mac_s. This loop makes back-to-back beats and zero-product bubbles accumulate correctly.
- res_valid timing: for last handshake at cycle t, res_valid rises at t+MULT_LAT+4. The captured value is the S_reg of the last beat.
- Config stability:
  - mac_mode and the signs are constant from job accept until the FSM returns to IDLE, so in-flight stages never see a mode change.
  - A new job is never accepted while beats are in flight or a result is pending.
- Arithmetic:
  - No interpretation of data: lane partitioning, sign handling and wrap-around are performed by the MAC.
  - Accumulation wraps mod 2^32, or per lane in SIMD modes. mac_cin=0.
- Simultaneous events: res_ready while res_valid=0 is ignored. op_valid outside RUN is not accepted (op_ready=0).

Test Plan:
- MULT_LAT=2, mode 0, unsigned, len=3, bias=10, beats (2,3),(4,5),(1,1) back-to-back from cycle t -> res_valid at t+2+6=t+8 with res_data=10+6+20+1=37.
- Same job with op_valid bubbles between every beat -> res_data=37; res_valid 6 cycles after the last handshake.
- len=0, bias=0xDEADBEEF -> res_valid one cycle after accept, res_data=0xDEADBEEF, res_carry=0, and no op_ready pulse.
- res_ready held low for 5 cycles after res_valid -> res_data stable and job_ready=0 throughout; job accepted the cycle after res_ready.
- Signed mode, a_sign=b_sign=1, len=2, bias=0, beats (-3,4),(2,2) -> res_data=0xFFFFFFF8 (-8).
- Reset pulsed during DRAIN -> no res_valid; all outputs 0; job_ready=1 next cycle; next job (len=1, bias=5, beat (7,1)) yields 12.

Source files
------------

// File: rtl/overlay_mac_job_sequencer.sv
// overlay_mac_job_sequencer
//
// Feeds dot-product / accumulate jobs into one Overlay C2x2 F1 16x16 MAC.
// A job config (SIMD mode, operand signs, beat count, 32-bit bias) is
// latched. The operand pairs are then streamed into the MAC a/b ports.
// The MAC accumulator input (result_2) selects the bias when the job's
// first product reaches the ALU stage. At every other time it selects the
// fed-back S_reg. When the last beat has drained, the final S_reg and the
// SIMD carries are returned on a valid/ready result port.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   job_*               job config handshake (mode, signs, len, bias)
//   op_*                operand pair stream handshake
//   mac_mode/a/b/signs  registered drive to the MAC operand ports
//   mac_result_2        accumulator input to the MAC (bias or S_reg)
//   mac_cin             MAC carry-in, tied to 0
//   mac_s, mac_carry    MAC S_reg and SIMD carry-out feedback
//   res_*               result handshake (final accumulator + carries)
module overlay_mac_job_sequencer #(
    parameter int MULT_LAT = 2,
    parameter int LEN_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [1:0]       job_mode,
    input  logic             job_a_sign,
    input  logic             job_b_sign,
    input  logic [LEN_W-1:0] job_len,
    input  logic [31:0]      job_bias,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [31:0]      op_a,
    input  logic [31:0]      op_b,
    output logic [1:0]       mac_mode,
    output logic [31:0]      mac_a,
    output logic [31:0]      mac_b,
    output logic             mac_a_sign,
    output logic             mac_b_sign,
    output logic [31:0]      mac_result_2,
    output logic             mac_cin,
    input  logic [31:0]      mac_s,
    input  logic [3:0]       mac_carry,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [3:0]       res_carry
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // The first-beat marker travels alongside the operand through the
    // register stage, the multiplier stages and the ALU input stage.
    localparam int FB_LEN  = MULT_LAT + 2;
    localparam int DRAIN_W = $clog2(MULT_LAT + 3) + 1;

    state_t             state;
    logic [LEN_W-1:0]   beat_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               first_pend;
    logic [FB_LEN-1:0]  first_p;
    logic [31:0]        bias;
    logic               job_hs;
    logic               op_hs;

    assign job_hs  = job_valid & job_ready;
    assign op_hs   = op_valid & op_ready;
    assign mac_cin = 1'b0;

    // The job's first product is seeded with the bias. Every later
    // product, and every zero-product bubble, adds onto S_reg.
    assign mac_result_2 = first_p[FB_LEN-1] ? bias : mac_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            job_ready  <= 1'b0;
            op_ready   <= 1'b0;
            beat_cnt   <= '0;
            drain_cnt  <= '0;
            first_pend <= 1'b0;
            first_p    <= '0;
            bias       <= '0;
            mac_mode   <= '0;
            mac_a      <= '0;
            mac_b      <= '0;
            mac_a_sign <= 1'b0;
            mac_b_sign <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_carry  <= '0;
        end else begin
            // Operand register stage: a cycle without a handshake
            // injects a zero-product bubble.
            first_p <= {first_p[FB_LEN-2:0], op_hs & first_pend};
            mac_a   <= op_hs ? op_a : 32'd0;
            mac_b   <= op_hs ? op_b : 32'd0;

            case (state)
                IDLE: begin
                    if (job_hs) begin
                        job_ready  <= 1'b0;
                        mac_mode   <= job_mode;
                        mac_a_sign <= job_a_sign;
                        mac_b_sign <= job_b_sign;
                        bias       <= job_bias;
                        beat_cnt   <= job_len;
                        first_pend <= 1'b1;
                        if (job_len == '0) begin
                            // No beats: the result is the bias itself.
                            res_valid <= 1'b1;
                            res_data  <= job_bias;
                            res_carry <= '0;
                            state     <= DONE;
                        end else begin
                            op_ready <= 1'b1;
                            state    <= RUN;
                        end
                    end else begin
                        job_ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (op_hs) begin
                        first_pend <= 1'b0;
                        beat_cnt   <= beat_cnt - LEN_W'(1);
                        if (beat_cnt == LEN_W'(1)) begin
                            op_ready  <= 1'b0;
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // S_reg of the last beat is present on the cycle
                    // after MULT_LAT+2 full drain cycles.
                    if (drain_cnt == DRAIN_W'(MULT_LAT + 2)) begin
                        res_valid <= 1'b1;
                        res_data  <= mac_s;
                        res_carry <= mac_carry;
                        state     <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        job_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_overlay_mac_job_sequencer.sv
// tb_overlay_mac_job_sequencer
//
// Directed bench for overlay_mac_job_sequencer. It includes a behavioural
// model of the MAC. In that model mac_a/mac_b pass through a product
// pipeline of MULT_LAT+1 stages into the ALU, and the ALU registers
// S = product + result_2 together with the 33rd-bit carry.
module tb_overlay_mac_job_sequencer;

    localparam int MULT_LAT = 2;
    localparam int LEN_W    = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             job_valid = 1'b0;
    logic             job_ready;
    logic [1:0]       job_mode = '0;
    logic             job_a_sign = 1'b0;
    logic             job_b_sign = 1'b0;
    logic [LEN_W-1:0] job_len = '0;
    logic [31:0]      job_bias = '0;
    logic             op_valid = 1'b0;
    logic             op_ready;
    logic [31:0]      op_a = '0;
    logic [31:0]      op_b = '0;
    logic [1:0]       mac_mode;
    logic [31:0]      mac_a;
    logic [31:0]      mac_b;
    logic             mac_a_sign;
    logic             mac_b_sign;
    logic [31:0]      mac_result_2;
    logic             mac_cin;
    logic [31:0]      mac_s = '0;
    logic [3:0]       mac_carry = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [31:0]      res_data;
    logic [3:0]       res_carry;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    overlay_mac_job_sequencer #(.MULT_LAT(MULT_LAT), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready), .job_mode(job_mode),
        .job_a_sign(job_a_sign), .job_b_sign(job_b_sign),
        .job_len(job_len), .job_bias(job_bias),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .mac_mode(mac_mode), .mac_a(mac_a), .mac_b(mac_b),
        .mac_a_sign(mac_a_sign), .mac_b_sign(mac_b_sign),
        .mac_result_2(mac_result_2), .mac_cin(mac_cin),
        .mac_s(mac_s), .mac_carry(mac_carry),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_carry(res_carry)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural MAC (mode 0: 16x16 product, 32-bit accumulate).
    function automatic logic [31:0] mul16(input logic [15:0] a, input logic [15:0] b,
                                          input logic sa, input logic sb);
        logic signed [16:0] ea;
        logic signed [16:0] eb;
        logic signed [33:0] p;
        ea = {sa & a[15], a};
        eb = {sb & b[15], b};
        p  = ea * eb;
        return p[31:0];
    endfunction

    logic [31:0] prod_p0 = '0;
    logic [31:0] prod_p1 = '0;
    logic [31:0] prod_p2 = '0;
    logic [32:0] sum;
    assign sum = {1'b0, prod_p2} + {1'b0, mac_result_2} + {32'd0, mac_cin};

    always @(posedge clk) begin
        prod_p0   <= mul16(mac_a[15:0], mac_b[15:0], mac_a_sign, mac_b_sign);
        prod_p1   <= prod_p0;
        prod_p2   <= prod_p1;
        mac_s     <= sum[31:0];
        mac_carry <= {3'b000, sum[32]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_job(input logic [1:0] m, input logic sa, input logic sb,
                            input logic [LEN_W-1:0] len, input logic [31:0] b,
                            output int hs);
        int n = 0;
        while (!job_ready && n < 20) begin
            tick();
            n++;
        end
        check("job_ready_wait", {31'd0, job_ready}, 32'd1);
        job_valid  = 1'b1;
        job_mode   = m;
        job_a_sign = sa;
        job_b_sign = sb;
        job_len    = len;
        job_bias   = b;
        hs = cyc;
        tick();
        job_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] a, input logic [31:0] b, output int hs);
        int n = 0;
        while (!op_ready && n < 20) begin
            tick();
            n++;
        end
        check("op_ready_wait", {31'd0, op_ready}, 32'd1);
        op_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        hs = cyc;
        tick();
        op_valid = 1'b0;
    endtask

    task automatic wait_res(output int at);
        int n = 0;
        while (!res_valid && n < 40) begin
            tick();
            n++;
        end
        check("res_valid_seen", {31'd0, res_valid}, 32'd1);
        at = cyc;
    endtask

    task automatic consume();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("res_valid_cleared", {31'd0, res_valid}, 32'd0);
    endtask

    initial begin
        int acc, last, rv, r, seen;

        // Reset state
        repeat (3) tick();
        check("rst_mac_a", mac_a, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_op_ready", {31'd0, op_ready}, 32'd0);
        check("rst_job_ready", {31'd0, job_ready}, 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_job_ready", {31'd0, job_ready}, 32'd1);

        // Back-to-back beats: 10 + 2*3 + 4*5 + 1*1 = 37
        send_job(2'd0, 1'b0, 1'b0, 16'd3, 32'd10, acc);
        send_beat(32'd2, 32'd3, last);
        check("b2b_first_beat_cycle", last - acc, 32'd1);
        send_beat(32'd4, 32'd5, last);
        send_beat(32'd1, 32'd1, last);
        check("b2b_op_ready_drop", {31'd0, op_ready}, 32'd0);
        wait_res(rv);
        check("b2b_latency", rv - last, 32'd6);
        check("b2b_data", res_data, 32'd37);
        check("b2b_carry", {28'd0, res_carry}, 32'd0);

        // Result held for 5 cycles with res_ready low
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_data", res_data, 32'd37);
            check("hold_valid", {31'd0, res_valid}, 32'd1);
            check("hold_job_ready", {31'd0, job_ready}, 32'd0);
        end
        res_ready = 1'b1;
        r = cyc;
        tick();
        res_ready = 1'b0;

        // Same job with bubbles; accepted the cycle after res_ready
        send_job(2'd0, 1'b0, 1'b0, 16'd3, 32'd10, acc);
        check("accept_after_ready", acc - r, 32'd1);
        send_beat(32'd2, 32'd3, last);
        tick();
        send_beat(32'd4, 32'd5, last);
        tick();
        tick();
        send_beat(32'd1, 32'd1, last);
        wait_res(rv);
        check("bub_latency", rv - last, 32'd6);
        check("bub_data", res_data, 32'd37);
        consume();

        // Wrap-around: 0xFFFFFFFF + 1 -> 0 with carry out
        send_job(2'd0, 1'b0, 1'b0, 16'd1, 32'hFFFF_FFFF, acc);
        send_beat(32'd1, 32'd1, last);
        wait_res(rv);
        check("wrap_data", res_data, 32'd0);
        check("wrap_carry", {28'd0, res_carry}, 32'd1);
        consume();

        // Zero-length job
        send_job(2'd1, 1'b0, 1'b0, 16'd0, 32'hDEAD_BEEF, acc);
        check("zl_res_valid", {31'd0, res_valid}, 32'd1);
        check("zl_data", res_data, 32'hDEAD_BEEF);
        check("zl_carry", {28'd0, res_carry}, 32'd0);
        check("zl_op_ready", {31'd0, op_ready}, 32'd0);
        check("zl_mode", {30'd0, mac_mode}, 32'd1);
        consume();

        // Signed: -3*4 + 2*2 = -8
        send_job(2'd0, 1'b1, 1'b1, 16'd2, 32'd0, acc);
        check("sgn_a_sign", {31'd0, mac_a_sign}, 32'd1);
        send_beat(32'hFFFF_FFFD, 32'd4, last);
        send_beat(32'd2, 32'd2, last);
        wait_res(rv);
        check("sgn_data", res_data, 32'hFFFF_FFF8);
        consume();

        // Reset during DRAIN
        send_job(2'd0, 1'b1, 1'b1, 16'd1, 32'd0, acc);
        send_beat(32'd5, 32'd5, last);
        tick();
        reset = 1'b1;
        tick();
        check("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("mid_rst_res_data", res_data, 32'd0);
        check("mid_rst_mac_a", mac_a, 32'd0);
        check("mid_rst_a_sign", {31'd0, mac_a_sign}, 32'd0);
        check("mid_rst_op_ready", {31'd0, op_ready}, 32'd0);
        reset = 1'b0;
        tick();
        check("mid_rst_job_ready", {31'd0, job_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (res_valid) seen++;
            tick();
        end
        check("mid_rst_no_result", seen, 32'd0);
        send_job(2'd0, 1'b0, 1'b0, 16'd1, 32'd5, acc);
        send_beat(32'd7, 32'd1, last);
        wait_res(rv);
        check("after_rst_latency", rv - last, 32'd6);
        check("after_rst_data", res_data, 32'd12);
        consume();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
